// File: rtl/lsu_mem_if.sv
// Load/store unit: turns core LB/LH/LW/LBU/LHU/SB/SH/SW requests into byte-enabled
// word transactions on the data-memory bus and stalls the core until the response.
module lsu_mem_if #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_misalign_o,
    output logic        core_timeout_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e          state_q, state_d;
    logic [1:0]      off_q, off_d;
    logic [2:0]      size_q, size_d;
    logic            we_q, we_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            legal;
    logic [3:0]      lane_be;
    logic [31:0]     lane_wd;
    logic            issue, stall, misalign, timeout;
    logic [31:0]     rd_ext;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    // Size decode, alignment and lane placement
    always_comb begin
        legal   = 1'b0;
        lane_be = 4'b0000;
        lane_wd = core_wd_i;
        case (core_size_i)
            3'd0, 3'd4: begin
                legal   = 1'b1;
                lane_be = 4'b0001 << core_addr_i[1:0];
                lane_wd = {4{core_wd_i[7:0]}};
            end
            3'd1, 3'd5: begin
                legal   = ~core_addr_i[0];
                lane_be = 4'b0011 << core_addr_i[1:0];
                lane_wd = {2{core_wd_i[15:0]}};
            end
            3'd2: begin
                legal   = (core_addr_i[1:0] == 2'b00);
                lane_be = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        off_d    = off_q;
        size_d   = size_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        issue    = 1'b0;
        stall    = 1'b0;
        misalign = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    if (legal) begin
                        issue = 1'b1;
                        stall = 1'b1;
                        if (mem_ready_i) begin
                            state_d = RESP;
                            off_d   = core_addr_i[1:0];
                            size_d  = core_size_i;
                            we_d    = core_we_i;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = CW'(1);
                        end
                    end else begin
                        misalign = 1'b1;
                    end
                end
            end
            WAIT: begin
                issue = 1'b1;
                stall = 1'b1;
                if (mem_ready_i) begin
                    state_d = RESP;
                    off_d   = core_addr_i[1:0];
                    size_d  = core_size_i;
                    we_d    = core_we_i;
                    cnt_d   = '0;
                end else if (TIMEOUT_CYCLES > 0 && cnt_q == TO_VAL) begin
                    // Give up: release the core and the bus in the same cycle
                    issue   = 1'b0;
                    stall   = 1'b0;
                    timeout = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Load data extraction from the word returned in RESP
    always_comb begin
        byte_sel = mem_rd_i[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        rd_ext   = '0;
        if (state_q == RESP && !we_q) begin
            case (size_q)
                3'd0:    rd_ext = {{24{byte_sel[7]}}, byte_sel};
                3'd4:    rd_ext = {24'd0, byte_sel};
                3'd1:    rd_ext = {{16{half_sel[15]}}, half_sel};
                3'd5:    rd_ext = {16'd0, half_sel};
                3'd2:    rd_ext = mem_rd_i;
                default: rd_ext = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            off_q   <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            size_q  <= size_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced low while reset is high, independent of the clock
    assign mem_req_o       = issue & ~rst_i;
    assign mem_we_o        = issue & core_we_i & ~rst_i;
    assign mem_be_o        = (issue & ~rst_i) ? lane_be : 4'b0000;
    assign mem_wd_o        = (issue & ~rst_i) ? lane_wd : 32'd0;
    assign mem_addr_o      = (issue & ~rst_i) ? core_addr_i : 32'd0;
    assign core_stall_o    = stall & ~rst_i;
    assign core_misalign_o = misalign & ~rst_i;
    assign core_timeout_o  = timeout & ~rst_i;
    assign core_rd_o       = rst_i ? 32'd0 : rd_ext;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: stimulus pushes expected bus transactions, load
// results and pulse events into queues; a negedge monitor pops and compares them.
module tb_lsu_mem_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we, mem_ready;
    logic [2:0]  core_size;
    logic [31:0] core_addr, core_wd, mem_rd;

    logic [31:0] rd4, rd0, waddr4, waddr0, wd4, wd0;
    logic        stall4, stall0, mis4, mis0, to4, to0, req4, req0, we4, we0;
    logic [3:0]  be4, be0;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] addr;
    } iss_t;

    iss_t        iss_q[$];
    logic [31:0] rsp_q[$];
    int          evt_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    lsu_mem_if #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst), .core_req_i(core_req), .core_we_i(core_we),
        .core_size_i(core_size), .core_addr_i(core_addr), .core_wd_i(core_wd),
        .core_rd_o(rd4), .core_stall_o(stall4), .core_misalign_o(mis4),
        .core_timeout_o(to4), .mem_req_o(req4), .mem_we_o(we4), .mem_be_o(be4),
        .mem_addr_o(waddr4), .mem_wd_o(wd4), .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
    );

    lsu_mem_if #(.TIMEOUT_CYCLES(0)) dut_nto (
        .clk_i(clk), .rst_i(rst), .core_req_i(core_req), .core_we_i(core_we),
        .core_size_i(core_size), .core_addr_i(core_addr), .core_wd_i(core_wd),
        .core_rd_o(rd0), .core_stall_o(stall0), .core_misalign_o(mis0),
        .core_timeout_o(to0), .mem_req_o(req0), .mem_we_o(we0), .mem_be_o(be0),
        .mem_addr_o(waddr0), .mem_wd_o(wd0), .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: RESP is the cycle after an accepted request
    logic resp_pend = 1'b0;
    always @(negedge clk) begin
        iss_t e;
        int   code;
        if (rst) begin
            resp_pend = 1'b0;
        end else if (resp_pend) begin
            resp_pend = 1'b0;
            chk("resp_stall", {31'd0, stall4}, 32'd0);
            chk("resp_req", {31'd0, req4}, 32'd0);
            if (rsp_q.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
            else                   chk("resp_rd", rd4, rsp_q.pop_front());
        end else begin
            chk("rd_not_resp", rd4, 32'd0);
            if (req4) begin
                chk("busy_stall", {31'd0, stall4}, 32'd1);
                if (iss_q.size() == 0) begin
                    chk("req_unexpected", 32'd1, 32'd0);
                end else begin
                    e = iss_q[0];
                    chk("mem_we", {31'd0, we4}, {31'd0, e.we});
                    chk("mem_be", {28'd0, be4}, {28'd0, e.be});
                    chk("mem_wd", wd4, e.wd);
                    chk("mem_addr", waddr4, e.addr);
                    if (mem_ready) begin
                        void'(iss_q.pop_front());
                        resp_pend = 1'b1;
                    end
                end
            end
            if (mis4 || to4) begin
                code = mis4 ? 1 : 2;
                chk("pulse_stall", {31'd0, stall4}, 32'd0);
                chk("pulse_req", {31'd0, req4}, 32'd0);
                if (evt_q.size() == 0) chk("pulse_unexpected", code, 32'd0);
                else                   chk("pulse_kind", code, evt_q.pop_front());
                if (to4 && iss_q.size() > 0) void'(iss_q.pop_front());
            end
        end
    end

    // Called at #1 after a posedge in IDLE; returns the same way with core_req low
    task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] mword, input int lows,
                          input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd);
        iss_t e;
        e.we = we; e.be = ebe; e.wd = ewd; e.addr = addr;
        iss_q.push_back(e);
        rsp_q.push_back(erd);
        core_req = 1'b1; core_we = we; core_size = sz; core_addr = addr; core_wd = wd;
        mem_ready = (lows == 0);
        repeat (lows) begin @(posedge clk); #1; end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        mem_rd = mword;
        @(posedge clk); #1;
        core_req = 1'b0; core_we = 1'b0; core_wd = '0; mem_rd = '0;
    endtask

    task automatic bad_req(input logic [2:0] sz, input logic [31:0] addr);
        evt_q.push_back(1);
        core_req = 1'b1; core_we = 1'b0; core_size = sz; core_addr = addr; core_wd = '0;
        @(posedge clk); #1;
        core_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        iss_t e;
        rst = 1'b1; core_req = 1'b1; core_we = 1'b1; core_size = 3'd2;
        core_addr = 32'h10; core_wd = 32'hFFFF_FFFF; mem_ready = 1'b1; mem_rd = 32'hFFFF_FFFF;
        #12;
        chk("rst_req", {31'd0, req4}, 32'd0);
        chk("rst_stall", {31'd0, stall4}, 32'd0);
        chk("rst_rd", rd4, 32'd0);
        chk("rst_be", {28'd0, be4}, 32'd0);
        core_req = 1'b0; core_we = 1'b0; core_wd = '0; mem_ready = 1'b0; mem_rd = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        access(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,         0, 4'b1111, 32'hDEADBEEF, 32'h0);
        access(1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF,  0, 4'b1111, 32'h0,        32'hDEADBEEF);
        access(1'b1, 3'd0, 32'h13, 32'h000000A5, 32'h0,         0, 4'b1000, 32'hA5A5A5A5, 32'h0);
        access(1'b0, 3'd0, 32'h13, 32'h0,        32'hA5000000,  0, 4'b1000, 32'h0,        32'hFFFFFFA5);
        access(1'b0, 3'd4, 32'h13, 32'h0,        32'hA5000000,  0, 4'b1000, 32'h0,        32'h000000A5);
        access(1'b0, 3'd1, 32'h22, 32'h0,        32'h80017FFF,  0, 4'b1100, 32'h0,        32'hFFFF8001);
        access(1'b0, 3'd5, 32'h22, 32'h0,        32'h80017FFF,  0, 4'b1100, 32'h0,        32'h00008001);
        access(1'b0, 3'd1, 32'h20, 32'h0,        32'h80017FFF,  0, 4'b0011, 32'h0,        32'h00007FFF);
        access(1'b0, 3'd0, 32'h11, 32'h0,        32'h0000C300,  0, 4'b0010, 32'h0,        32'hFFFFFFC3);
        access(1'b1, 3'd1, 32'h16, 32'h1234BEEF, 32'h0,         0, 4'b1100, 32'hBEEFBEEF, 32'h0);
        bad_req(3'd1, 32'h21);
        bad_req(3'd2, 32'h26);
        bad_req(3'd3, 32'h20);
        access(1'b0, 3'd2, 32'h24, 32'h0,        32'h12345678,  3, 4'b1111, 32'h0,        32'h12345678);

        // Memory never ready: the TIMEOUT_CYCLES=4 instance gives up, the other keeps waiting
        e.we = 1'b0; e.be = 4'b1111; e.wd = 32'h0; e.addr = 32'h40;
        iss_q.push_back(e);
        evt_q.push_back(2);
        core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h40; mem_ready = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        core_req = 1'b0;
        @(negedge clk);
        chk("nto_stall", {31'd0, stall0}, 32'd1);
        chk("nto_req", {31'd0, req0}, 32'd1);
        chk("nto_addr", waddr0, 32'h40);
        chk("nto_pulse", {31'd0, to0}, 32'd0);
        @(posedge clk); #1;
        chk("to_idle_stall", {31'd0, stall4}, 32'd0);
        chk("nto_still_stall", {31'd0, stall0}, 32'd1);

        // Asynchronous reset while waiting, then a fresh access out of reset
        e.addr = 32'h50;
        iss_q.push_back(e);
        core_req = 1'b1; core_addr = 32'h50;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_req", {31'd0, req4}, 32'd0);
        chk("arst_stall", {31'd0, stall4}, 32'd0);
        chk("arst_req_nto", {31'd0, req0}, 32'd0);
        chk("arst_stall_nto", {31'd0, stall0}, 32'd0);
        iss_q.delete();
        @(posedge clk); #1;
        e.addr = 32'h10;
        iss_q.push_back(e);
        rsp_q.push_back(32'hDEADBEEF);
        core_addr = 32'h10; mem_ready = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
        mem_ready = 1'b0; mem_rd = 32'hDEADBEEF;
        @(posedge clk); #1;
        core_req = 1'b0; mem_rd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("iss_left", iss_q.size(), 32'd0);
        chk("rsp_left", rsp_q.size(), 32'd0);
        chk("evt_left", evt_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
